// File: rtl/two_ask_demod.sv
// Non-coherent 2ASK demodulator: aligns to the first carrier burst, counts high
// samples over each symbol and slices the count against a threshold.
module two_ask_demod #(
    parameter int SYM_LEN  = 16,
    parameter int THRESH   = 4,
    parameter int MAX_ZERO = 8,
    parameter int CNT_W    = 5,
    parameter int ZR_W     = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic din,
    output logic dout,
    output logic dout_valid,
    output logic lock
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HUNT  = 2'd1,
        TRACK = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_POS  = CNT_W'(SYM_LEN - 1);
    localparam logic [ZR_W-1:0]  LAST_ZERO = ZR_W'(MAX_ZERO - 1);
    localparam logic [31:0]      THRESH_U  = 32'(THRESH);

    state_t            state, state_next;
    logic [CNT_W-1:0]  pos, pos_next;
    logic [CNT_W-1:0]  acc, acc_next;
    logic [ZR_W-1:0]   zrun, zrun_next;
    logic              dout_next;
    logic              valid_next;
    logic [CNT_W-1:0]  total;
    logic              decision;

    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        pos_next   = pos;
        acc_next   = acc;
        zrun_next  = zrun;
        dout_next  = dout;
        valid_next = 1'b0;
        total      = acc + {{(CNT_W-1){1'b0}}, din};
        decision   = ({{(32-CNT_W){1'b0}}, total} >= THRESH_U);

        unique case (state)
            IDLE: begin
                if (en) state_next = HUNT;
            end
            HUNT: begin
                if (!en) begin
                    state_next = IDLE;
                    pos_next   = '0;
                    acc_next   = '0;
                    zrun_next  = '0;
                end else if (din) begin
                    // This edge is sample 0 of the first symbol.
                    state_next = TRACK;
                    pos_next   = CNT_W'(1);
                    acc_next   = CNT_W'(1);
                end
            end
            TRACK: begin
                if (!en) begin
                    state_next = IDLE;
                    pos_next   = '0;
                    acc_next   = '0;
                    zrun_next  = '0;
                end else if (pos == LAST_POS) begin
                    dout_next  = decision;
                    valid_next = 1'b1;
                    pos_next   = '0;
                    acc_next   = '0;
                    if (decision) begin
                        zrun_next = '0;
                    end else if (zrun == LAST_ZERO) begin
                        // Too many silent symbols: drop lock and re-hunt.
                        state_next = HUNT;
                        zrun_next  = '0;
                    end else begin
                        zrun_next = zrun + ZR_W'(1);
                    end
                end else begin
                    pos_next = pos + CNT_W'(1);
                    acc_next = total;
                end
            end
            default: begin
                state_next = IDLE;
                pos_next   = '0;
                acc_next   = '0;
                zrun_next  = '0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop sees
    // the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            pos        <= '0;
            acc        <= '0;
            zrun       <= '0;
            dout       <= 1'b0;
            dout_valid <= 1'b0;
            lock       <= 1'b0;
        end else begin
            state      <= state_next;
            pos        <= pos_next;
            acc        <= acc_next;
            zrun       <= zrun_next;
            dout       <= dout_next;
            dout_valid <= valid_next;
            lock       <= (state_next == TRACK);
        end
    end

endmodule
